// File: rtl/logic_ops_pkg.sv
// Shared encodings for the bitwise logic datapath.
//   op_e    : per-beat operation select (XOR, AND, OR, XNOR)
//   state_e : packet FSM state (IDLE = between packets, ACC = mid-packet)
package logic_ops_pkg;

    typedef enum logic [1:0] {
        OP_XOR  = 2'd0,
        OP_AND  = 2'd1,
        OP_OR   = 2'd2,
        OP_XNOR = 2'd3
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_e;

endpackage

// File: rtl/bitwise_op_n.sv
// Purely combinational N-bit bitwise operator: y = a <op> b.
// Ports:
//   a, b : N-bit operands
//   op   : operation select (OP_XOR / OP_AND / OP_OR / OP_XNOR)
//   y    : N-bit result, no carries between bit positions
module bitwise_op_n
    import logic_ops_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   op,
    output logic [N-1:0] y
);

    for (genvar k = 0; k < N; k++) begin : g_bit
        assign y[k] = (op == OP_XOR) ? (a[k] ^ b[k]) :
                      (op == OP_AND) ? (a[k] & b[k]) :
                      (op == OP_OR)  ? (a[k] | b[k]) :
                                       ~(a[k] ^ b[k]);
    end

endmodule

// File: rtl/bitwise_logic_acc.sv
// Pipelined bitwise XOR/AND/OR/XNOR unit with optional multi-beat
// accumulation (e.g. running XOR checksums, mask merges).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input beat handshake
//   op, acc_mode, last  : beat operation, packet mode, final-beat flag
//   i0, i1              : operands (i1 only used on a packet's first beat)
//   out_valid/out_ready : result handshake
//   out, out_parity,
//   out_zero, out_beats : registered result word, its parity, zero flag
//                         and the (saturating) number of beats folded in
module bitwise_logic_acc
    import logic_ops_pkg::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             acc_mode,
    input  logic             last,
    input  logic [N-1:0]     i0,
    input  logic [N-1:0]     i1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out,
    output logic             out_parity,
    output logic             out_zero,
    output logic [CNT_W-1:0] out_beats
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_ONE;
    endfunction

    state_e           state_p1, state_nxt;
    logic [N-1:0]     acc_p1;
    logic [CNT_W-1:0] cnt_p1;
    logic [1:0]       op_p1;

    logic [N-1:0]     first_res, fold_res, res_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             accept, load_acc, load_out, latch_op;

    // Ready depends only on the output register, so a stalled consumer
    // stalls the producer in either FSM state; held low during reset.
    assign in_ready = !rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // ---- stage p0: first-beat and fold operators ----
    bitwise_op_n #(.N(N)) u_first (
        .a  (i0),
        .b  (i1),
        .op (op),
        .y  (first_res)
    );

    bitwise_op_n #(.N(N)) u_fold (
        .a  (acc_p1),
        .b  (i0),
        .op (op_p1),
        .y  (fold_res)
    );

    always_comb begin
        state_nxt = state_p1;
        res_nxt   = first_res;
        cnt_nxt   = CNT_ONE;
        load_acc  = 1'b0;
        load_out  = 1'b0;
        latch_op  = 1'b0;
        unique case (state_p1)
            ST_IDLE: begin
                if (accept) begin
                    if (!acc_mode || last) begin
                        load_out = 1'b1;
                    end else begin
                        load_acc  = 1'b1;
                        latch_op  = 1'b1;
                        state_nxt = ST_ACC;
                    end
                end
            end
            ST_ACC: begin
                res_nxt = fold_res;
                cnt_nxt = sat_inc(cnt_p1);
                if (accept) begin
                    if (last) begin
                        load_out  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        load_acc = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---- stage p1: accumulator, FSM state and output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1   <= ST_IDLE;
            acc_p1     <= '0;
            cnt_p1     <= '0;
            op_p1      <= OP_XOR;
            out_valid  <= 1'b0;
            out        <= '0;
            out_parity <= 1'b0;
            out_zero   <= 1'b1;
            out_beats  <= '0;
        end else begin
            state_p1 <= state_nxt;
            if (load_acc) begin
                acc_p1 <= res_nxt;
                cnt_p1 <= cnt_nxt;
            end
            if (latch_op) begin
                op_p1 <= op;
            end
            if (load_out) begin
                out        <= res_nxt;
                out_parity <= ^res_nxt;
                out_zero   <= (res_nxt == '0);
                out_beats  <= cnt_nxt;
                out_valid  <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bitwise_logic_acc.sv
module tb_bitwise_logic_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // main instance: N=32, CNT_W=8
    logic        in_valid, in_ready, acc_mode, last, out_valid, out_ready;
    logic        out_parity, out_zero;
    logic [1:0]  op;
    logic [31:0] i0, i1, out;
    logic [7:0]  out_beats;

    // saturation instance: CNT_W=2
    logic        s_in_valid, s_in_ready, s_acc_mode, s_last, s_out_valid, s_out_ready;
    logic        s_out_parity, s_out_zero;
    logic [1:0]  s_op, s_out_beats;
    logic [31:0] s_i0, s_i1, s_out;

    // single-bit instance: N=1
    logic        n_in_valid, n_in_ready, n_acc_mode, n_last, n_out_valid, n_out_ready;
    logic        n_out_parity, n_out_zero;
    logic [1:0]  n_op;
    logic [0:0]  n_i0, n_i1, n_out;
    logic [7:0]  n_out_beats;

    bitwise_logic_acc #(.N(32), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .acc_mode(acc_mode), .last(last), .i0(i0), .i1(i1), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .out_parity(out_parity), .out_zero(out_zero),
        .out_beats(out_beats)
    );

    bitwise_logic_acc #(.N(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op),
        .acc_mode(s_acc_mode), .last(s_last), .i0(s_i0), .i1(s_i1), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out(s_out), .out_parity(s_out_parity), .out_zero(s_out_zero),
        .out_beats(s_out_beats)
    );

    bitwise_logic_acc #(.N(1), .CNT_W(8)) dut_n1 (
        .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready), .op(n_op),
        .acc_mode(n_acc_mode), .last(n_last), .i0(n_i0), .i1(n_i1), .out_valid(n_out_valid),
        .out_ready(n_out_ready), .out(n_out), .out_parity(n_out_parity), .out_zero(n_out_zero),
        .out_beats(n_out_beats)
    );

    typedef struct {
        logic [1:0]  op;
        logic        am;
        logic        lst;
        logic [31:0] a;
        logic [31:0] b;
        logic        has;
        logic [31:0] eo;
        logic [7:0]  eb;
    } vec_t;

    typedef struct {
        logic [31:0] o;
        logic [7:0]  beats;
    } res_t;

    vec_t vecs[13];
    res_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic send(input logic [1:0] o, input logic am, input logic lst,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic has, input logic [31:0] eo, input logic [7:0] eb);
        res_t r;
        int   n;
        @(negedge clk);
        in_valid = 1'b1; op = o; acc_mode = am; last = lst; i0 = a; i1 = b;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
        end else if (has) begin
            r.o = eo;
            r.beats = eb;
            exp_q.push_back(r);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{2'd0, 1'b0, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1, 32'hFF00_EDCB, 8'd1};
        vecs[1]  = '{2'd1, 1'b0, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1, 32'h00F0_1234, 8'd1};
        vecs[2]  = '{2'd2, 1'b0, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1, 32'hFFF0_FFFF, 8'd1};
        vecs[3]  = '{2'd3, 1'b0, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1, 32'h00FF_1234, 8'd1};
        vecs[4]  = '{2'd0, 1'b1, 1'b0, 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0, 8'd0};
        vecs[5]  = '{2'd1, 1'b1, 1'b0, 32'h0000_0004, 32'hDEAD_BEEF, 1'b0, 32'h0, 8'd0};
        vecs[6]  = '{2'd2, 1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678, 1'b1, 32'h0000_000F, 8'd3};
        vecs[7]  = '{2'd1, 1'b1, 1'b1, 32'h0000_00FF, 32'h0000_000F, 1'b1, 32'h0000_000F, 8'd1};
        vecs[8]  = '{2'd1, 1'b1, 1'b0, 32'hFFFF_0000, 32'hF0F0_F0F0, 1'b0, 32'h0, 8'd0};
        vecs[9]  = '{2'd2, 1'b1, 1'b1, 32'h0FF0_0FF0, 32'h1234_5678, 1'b1, 32'h00F0_0000, 8'd2};
        vecs[10] = '{2'd3, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0, 8'd0};
        vecs[11] = '{2'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hAAAA_5555, 1'b1, 32'hFFFF_FFFF, 8'd2};
        vecs[12] = '{2'd2, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 8'd1};

        rst = 1'b1;
        in_valid = 0; op = 0; acc_mode = 0; last = 0; i0 = 0; i1 = 0; out_ready = 1;
        s_in_valid = 0; s_op = 0; s_acc_mode = 0; s_last = 0; s_i0 = 0; s_i1 = 0; s_out_ready = 1;
        n_in_valid = 0; n_op = 0; n_acc_mode = 0; n_last = 0; n_i0 = 0; n_i1 = 0; n_out_ready = 1;

        // scoreboard monitor
        fork
            forever begin
                @(negedge clk);
                if (mon_en && !rst && out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", out, 32'hxxxx_xxxx);
                    end else begin
                        res_t r;
                        r = exp_q.pop_front();
                        check("sb_out", out, r.o);
                        check("sb_parity", 32'(out_parity), 32'(^r.o));
                        check("sb_zero", 32'(out_zero), 32'(r.o == 32'h0));
                        check("sb_beats", 32'(out_beats), 32'(r.beats));
                    end
                end
            end
        join_none

        // reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", out, 32'd0);
        check("rst_parity", 32'(out_parity), 32'd0);
        check("rst_zero", 32'(out_zero), 32'd1);
        check("rst_beats", 32'(out_beats), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // table-driven beats with out_ready=1
        for (int k = 0; k < 13; k++)
            send(vecs[k].op, vecs[k].am, vecs[k].lst, vecs[k].a, vecs[k].b,
                 vecs[k].has, vecs[k].eo, vecs[k].eb);
        repeat (4) @(negedge clk);
        check("table_queue_empty", 32'(exp_q.size()), 32'd0);
        check("table_drained", 32'(out_valid), 32'd0);

        // back-pressure: hold result, then drain and load in one cycle
        mon_en = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1; op = 2'd0; acc_mode = 1'b0; last = 1'b0;
        i0 = 32'h0000_000A; i1 = 32'h0000_0005;
        @(negedge clk);
        op = 2'd2; i0 = 32'h0000_0030; i1 = 32'h0000_0003;
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_out", out, 32'h0000_000F);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_out", out, 32'h0000_000F);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1 check("bp_in_ready_high", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_swap_out", out, 32'h0000_0033);
        check("bp_swap_valid", 32'(out_valid), 32'd1);
        check("bp_swap_beats", 32'(out_beats), 32'd1);
        @(negedge clk);
        check("bp_drain_valid", 32'(out_valid), 32'd0);
        check("bp_drain_hold", out, 32'h0000_0033);
        mon_en = 1'b1;

        // reset mid-packet discards the partial AND accumulation
        send(2'd1, 1'b1, 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0, 32'h0, 8'd0);
        send(2'd1, 1'b1, 1'b0, 32'h00FF_FF00, 32'h0, 1'b0, 32'h0, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_zero", 32'(out_zero), 32'd1);
        check("mid_rst_beats", 32'(out_beats), 32'd0);
        rst = 1'b0;
        send(2'd0, 1'b0, 1'b0, 32'h0000_000A, 32'h0000_0005, 1'b1, 32'h0000_000F, 8'd1);
        send(2'd0, 1'b1, 1'b0, 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0, 8'd0);
        send(2'd0, 1'b1, 1'b1, 32'h0000_0004, 32'h0, 1'b1, 32'h0000_0007, 8'd2);
        repeat (4) @(negedge clk);
        check("post_rst_queue_empty", 32'(exp_q.size()), 32'd0);

        // beat counter saturation with CNT_W=2
        @(negedge clk);
        s_in_valid = 1'b1; s_op = 2'd2; s_acc_mode = 1'b1; s_i0 = 32'h0; s_i1 = 32'h0;
        for (int k = 0; k < 5; k++) begin
            s_last = (k == 4);
            check("sat_in_ready", 32'(s_in_ready), 32'd1);
            check("sat_no_early_valid", 32'(s_out_valid), 32'd0);
            @(negedge clk);
        end
        s_in_valid = 1'b0; s_last = 1'b0;
        check("sat_valid", 32'(s_out_valid), 32'd1);
        check("sat_out", s_out, 32'h0);
        check("sat_zero", 32'(s_out_zero), 32'd1);
        check("sat_beats", 32'(s_out_beats), 32'd3);

        // N=1 build
        n_in_valid = 1'b1; n_op = 2'd3; n_acc_mode = 1'b0; n_i0 = 1'b1; n_i1 = 1'b1;
        @(negedge clk);
        n_op = 2'd0;
        check("n1_xnor_out", 32'(n_out), 32'd1);
        check("n1_xnor_parity", 32'(n_out_parity), 32'd1);
        check("n1_xnor_zero", 32'(n_out_zero), 32'd0);
        @(negedge clk);
        n_in_valid = 1'b0;
        check("n1_xor_out", 32'(n_out), 32'd0);
        check("n1_xor_parity", 32'(n_out_parity), 32'd0);
        check("n1_xor_zero", 32'(n_out_zero), 32'd1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bitwise_logic_acc.md
Name: bitwise_logic_acc

Overview:
- Parametrised, pipelined successor to the combinational per-bit XOR slice.
- Computes XOR/AND/OR/XNOR of two N-bit operands per beat, behind a valid/ready handshake and a registered output.
- Optional accumulate mode folds a multi-beat packet into one result word, e.g. running XOR checksums or mask merges.
- Sits between datapath producers and checksum/compare logic in the synthesis test designs.

Parameters:
- N, 32, operand/result width in bits (≥1).
- CNT_W, 8, width of the beat counter reported with each result.

Ports:
- clk  input  1  rising-edge clock, single domain.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts beat this cycle.
- op  input  2  operation: 0 XOR, 1 AND, 2 OR, 3 XNOR.
- acc_mode  input  1  1 = beat belongs to an accumulate packet.
- last  input  1  final beat of accumulate packet; ignored when acc_mode=0.
- i0  input  N  operand A.
- i1  input  N  operand B; used only on the first beat of a packet.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out  output  N  result word.
- out_parity  output  1  XOR-reduction of out.
- out_zero  output  1  1 when out == 0.
- out_beats  output  CNT_W  beats folded into out; saturating.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - out_valid=0, out=0, out_parity=0, out_zero=1, out_beats=0.
  - FSM goes to IDLE; accumulator cleared.
  - A partially accumulated packet is discarded, never emitted.
- Acceptance:
  - Beat accepted when in_valid && in_ready.
  - in_ready = !out_valid || out_ready, a combinational pass-through of out_ready, identical in both FSM states.
  - in_ready is 0 while rst=1.
- Output register:
  - out/out_parity/out_zero/out_beats change only when a result is loaded.
  - Held stable while out_valid && !out_ready.
  - out_valid clears on out_ready unless a new result loads in the same cycle.
- FSM IDLE, accepted beat with acc_mode=0:
  - out = i0 op i1, out_beats=1, out_valid=1 next cycle (latency 1).
  - Stays IDLE.
- FSM IDLE, accepted beat with acc_mode=1, last=0:
  - acc = i0 op i1; op latched as op_q; beat count = 1; go to ACC.
  - No output.
- FSM IDLE, accepted beat with acc_mode=1, last=1:
  - Single-beat packet, same result as acc_mode=0; stays IDLE.
- FSM ACC, accepted beat:
  - acc = acc op_q i0; i1, the beat's op and acc_mode are ignored.
  - Count increments, saturating at 2^CNT_W-1.
  - If last=1: load out = new acc, out_beats = new count, out_valid=1 next cycle, return to IDLE.
- Simultaneous output drain and new load in one cycle: the new result replaces the old one; out_valid stays 1.
- Back-pressure mid-packet: beats stall via in_ready; the accumulator holds.
- Width rules:
  - All ops bitwise over N bits, no carries.
  - XNOR = ~(a ^ b), masked to N bits.
  - out_parity and out_zero are computed from the value being loaded, so they are registered with it.

Decomposition:
- Shared package `logic_ops_pkg`:
  - Op encodings OP_XOR=0, OP_AND=1, OP_OR=2, OP_XNOR=3.
  - FSM state encodings ST_IDLE, ST_ACC.
- One natural sub-module `bitwise_op_n` (N-parameter, purely combinational, generate loop per bit): f(a, b, op).
  - Instantiated twice: first-beat path (i0,i1) and fold path (acc,i0). Alternatively muxed into a single instance.

Test Plan:
- Single beats, out_ready=1, op=0..3, i0=32'hF0F0_1234, i1=32'h0FF0_FFFF → next cycle out = 32'hFF00_EDCB / 32'h00F0_1234 / 32'hFFF0_FFFF / 32'h00FF_1234.
  - out_parity = XOR-reduction of each expected word.
  - out_beats=1; one result per accepted beat.
- XOR packet of 3 beats: (i0=32'h1, i1=32'h2), then i0=32'h4, then i0=32'h8 with last=1 → one result out=32'hF, out_beats=3, out_parity=0, no intermediate out_valid.
- Back-pressure: out_ready=0 with a result pending → in_ready=0, out stays constant for 5 cycles; raising out_ready with a new in_valid beat → old result drains and new one loads in the same cycle.
- Reset mid-packet: 2 beats of an AND packet, then rst=1 for 1 cycle → out_valid=0, out_zero=1.
  - A following single XOR beat (32'hA, 32'h5) yields 32'hF; no stale accumulator.
- Saturation, CNT_W=2: 5-beat OR packet of 32'h0 → out=0, out_zero=1, out_beats=3.
- N=1 build: op=3 with i0=1, i1=1 → out=1 (XNOR), out_parity=1.
